// File: rtl/mem_io_responder.sv
// Far-end responder for the CPU memory bus: program/data RAM, UART byte port with TX FIFO,
// and the cycle-counter / program-stop port. Read data is registered with one cycle of latency.
module mem_io_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_DEPTH_LOG   = 3,
  parameter int FULL_MARGIN    = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_wdata,
  output logic [7:0]  mem_rdata,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        program_stop,
  output logic        tx_overflow
);

  localparam int LP_DEPTH = 2 ** TX_DEPTH_LOG;
  localparam logic [TX_DEPTH_LOG:0] LP_DEPTH_CNT = (TX_DEPTH_LOG + 1)'(LP_DEPTH);
  localparam logic [TX_DEPTH_LOG:0] LP_FULL_TH   = (TX_DEPTH_LOG + 1)'(LP_DEPTH - FULL_MARGIN);

  logic [17:0]               w_addr;
  logic [RAM_ADDR_WIDTH-1:0] w_ram_idx;
  logic                      w_ram_sel;
  logic                      w_io_sel;
  logic                      w_io_data;
  logic                      w_io_cnt;
  logic [7:0]                w_io_byte;
  logic                      w_unused;

  logic [7:0]  r_ram [2**RAM_ADDR_WIDTH];
  logic [31:0] r_cnt;
  logic [31:0] r_snap;
  logic        r_stop;

  logic [7:0]              r_tx_mem [LP_DEPTH];
  logic [TX_DEPTH_LOG-1:0] r_wr_ptr;
  logic [TX_DEPTH_LOG-1:0] r_rd_ptr;
  logic [TX_DEPTH_LOG:0]   r_tx_cnt;
  logic                    r_tx_ovf;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_accept;
  logic [7:0]              w_push_byte;

  assign w_addr    = mem_a[17:0];
  assign w_ram_idx = mem_a[RAM_ADDR_WIDTH-1:0];
  assign w_ram_sel = ~w_addr[17];
  assign w_io_sel  = (w_addr[17:16] == 2'b11);
  assign w_io_data = w_io_sel && (w_addr[2:0] == 3'd0);
  assign w_io_cnt  = w_io_sel && (w_addr[2:0] == 3'd4);
  assign w_unused  = ^mem_a[31:18];

  assign rx_ready = ~rst_in & ~mem_wr & (w_addr == 18'h30000) & rx_valid;

  always_comb begin
    w_io_byte = 8'h00;
    case (w_addr[2:0])
      3'd0:    w_io_byte = rx_valid ? rx_data : 8'h00;
      3'd4:    w_io_byte = r_cnt[7:0];
      3'd5:    w_io_byte = r_snap[15:8];
      3'd6:    w_io_byte = r_snap[23:16];
      3'd7:    w_io_byte = r_snap[31:24];
      default: w_io_byte = 8'h00;
    endcase
  end

  // RAM has no reset so its contents survive a CPU restart.
  always_ff @(posedge clk_in) begin
    if (mem_wr && w_ram_sel) begin
      r_ram[w_ram_idx] <= mem_wdata;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_rdata <= 8'h00;
    end else if (!mem_wr) begin
      if (w_ram_sel) begin
        mem_rdata <= r_ram[w_ram_idx];
      end else if (w_io_sel) begin
        mem_rdata <= w_io_byte;
      end else begin
        mem_rdata <= 8'h00;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_cnt  <= 32'd0;
      r_snap <= 32'd0;
      r_stop <= 1'b0;
    end else begin
      if (!r_stop) begin
        r_cnt <= r_cnt + 32'd1;
      end
      if (!mem_wr && w_io_cnt) begin
        r_snap <= r_cnt;
      end
      if (mem_wr && w_io_cnt) begin
        r_stop <= 1'b1;
      end
    end
  end

  assign program_stop = r_stop;

  // The stop write pushes a 0x00 marker, so it bypasses the zero filter on the data port.
  assign w_push      = mem_wr & ((w_io_data & (|mem_wdata)) | w_io_cnt);
  assign w_push_byte = w_io_cnt ? 8'h00 : mem_wdata;
  assign w_pop       = tx_valid & tx_ready;
  assign w_accept    = w_push & ((r_tx_cnt < LP_DEPTH_CNT) | w_pop);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_tx_cnt <= '0;
      r_tx_ovf <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + TX_DEPTH_LOG'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + TX_DEPTH_LOG'(1);
      end
      if (w_accept && !w_pop) begin
        r_tx_cnt <= r_tx_cnt + (TX_DEPTH_LOG + 1)'(1);
      end else if (w_pop && !w_accept) begin
        r_tx_cnt <= r_tx_cnt - (TX_DEPTH_LOG + 1)'(1);
      end
      if (w_push && !w_accept) begin
        r_tx_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_accept) begin
      r_tx_mem[r_wr_ptr] <= w_push_byte;
    end
  end

  assign tx_valid       = (r_tx_cnt != '0);
  assign tx_data        = r_tx_mem[r_rd_ptr];
  assign io_buffer_full = (r_tx_cnt >= LP_FULL_TH);
  assign tx_overflow    = r_tx_ovf;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: read-data and TX scoreboards fed at stimulus time,
// popped when the DUT presents the corresponding output.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        io_buffer_full;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        program_stop;
  logic        tx_overflow;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [7:0]  q_rd[$];
  logic [7:0]  q_tx[$];
  logic        exp_ovf;
  logic [31:0] model_cnt  = 32'd0;
  logic        model_stop = 1'b0;
  logic [31:0] snap;

  always #5 clk_in = ~clk_in;

  mem_io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .io_buffer_full(io_buffer_full),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .program_stop(program_stop), .tx_overflow(tx_overflow)
  );

  // Reference cycle counter: counts every non-reset edge until the stop write lands.
  always @(posedge clk_in) begin
    if (rst_in) begin
      model_cnt  = 32'd0;
      model_stop = 1'b0;
    end else begin
      if (!model_stop) model_cnt = model_cnt + 32'd1;
      if (mem_wr && mem_a[17:0] == 18'h30004) model_stop = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    mem_a  = 32'h0;
    mem_wr = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [31:0] addr, input logic [7:0] exp);
    logic [7:0] e;
    mem_a     = addr;
    mem_wr    = 1'b0;
    mem_wdata = 8'h00;
    q_rd.push_back(exp);
    tick();
    e = q_rd.pop_front();
    chk($sformatf("rd_%h", addr), 32'(mem_rdata), 32'(e));
  endtask

  task automatic wr(input logic [31:0] addr, input logic [7:0] d);
    logic [7:0] prev;
    prev      = mem_rdata;
    mem_a     = addr;
    mem_wr    = 1'b1;
    mem_wdata = d;
    tick();
    mem_wr = 1'b0;
    mem_a  = 32'h0;
    chk($sformatf("wr_hold_%h", addr), 32'(mem_rdata), 32'(prev));
  endtask

  task automatic chk_tx();
    chk("tx_valid", 32'(tx_valid), 32'(q_tx.size() != 0));
    chk("io_buffer_full", 32'(io_buffer_full), 32'(q_tx.size() >= 6));
    chk("tx_overflow", 32'(tx_overflow), 32'(exp_ovf));
    if (q_tx.size() != 0) chk("tx_head", 32'(tx_data), 32'(q_tx[0]));
  endtask

  task automatic tx_wr(input logic [31:0] addr, input logic [7:0] d);
    logic is_stop;
    is_stop = (addr[17:0] == 18'h30004);
    if (tx_ready && q_tx.size() != 0) begin
      chk("tx_pop_data", 32'(tx_data), 32'(q_tx[0]));
      q_tx.delete(0);
    end
    if (is_stop || d != 8'h00) begin
      if (q_tx.size() < 8) q_tx.push_back(is_stop ? 8'h00 : d);
      else exp_ovf = 1'b1;
    end
    wr(addr, d);
    chk_tx();
  endtask

  task automatic pop_n(input int n);
    tx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk("pop_valid", 32'(tx_valid), 32'(1));
      chk("pop_data", 32'(tx_data), 32'(q_tx[0]));
      q_tx.delete(0);
      idle();
    end
    tx_ready = 1'b0;
    chk_tx();
  endtask

  task automatic drain();
    int n_exp;
    int n;
    n_exp    = q_tx.size();
    n        = 0;
    mem_a    = 32'h0;
    mem_wr   = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 20 && tx_valid; i++) begin
      if (q_tx.size() != 0) begin
        chk("drain_data", 32'(tx_data), 32'(q_tx[0]));
        q_tx.delete(0);
      end
      n++;
      tick();
    end
    tx_ready = 1'b0;
    chk("drain_count", 32'(n), 32'(n_exp));
    chk("drain_empty", 32'(tx_valid), 32'(0));
    q_tx.delete();
  endtask

  initial begin
    rst_in    = 1'b1;
    mem_a     = 32'h30000;
    mem_wr    = 1'b0;
    mem_wdata = 8'h00;
    tx_ready  = 1'b0;
    rx_valid  = 1'b1;
    rx_data   = 8'h99;
    exp_ovf   = 1'b0;
    repeat (3) tick();
    chk("rst_rdata", 32'(mem_rdata), 32'(0));
    chk("rst_tx_valid", 32'(tx_valid), 32'(0));
    chk("rst_full", 32'(io_buffer_full), 32'(0));
    chk("rst_stop", 32'(program_stop), 32'(0));
    chk("rst_ovf", 32'(tx_overflow), 32'(0));
    chk("rst_rx_ready", 32'(rx_ready), 32'(0));
    rst_in   = 1'b0;
    rx_valid = 1'b0;
    mem_a    = 32'h0;

    // RAM, hole and write-then-read
    wr(32'h00010, 8'hA5);
    wr(32'h1FFFF, 8'h3C);
    rd(32'h00010, 8'hA5);
    rd(32'h1FFFF, 8'h3C);
    rd(32'h20000, 8'h00);
    wr(32'h20000, 8'h77);
    rd(32'h20000, 8'h00);
    wr(32'h00020, 8'h5A);
    rd(32'h00020, 8'h5A);
    rd(32'h00010, 8'hA5);

    // TX path with zero filter
    tx_wr(32'h30000, 8'h48);
    tx_wr(32'h30000, 8'h00);
    tx_wr(32'h30000, 8'h69);
    drain();

    // Backpressure, overflow, push during pop at full
    for (int d = 1; d <= 9; d++) tx_wr(32'h30000, 8'(d));
    tx_ready = 1'b1;
    tx_wr(32'h30000, 8'h0A);
    tx_ready = 1'b0;
    drain();

    // RX handshake
    rx_valid = 1'b1;
    rx_data  = 8'h37;
    mem_a    = 32'h30000;
    mem_wr   = 1'b0;
    #1 chk("rx_ready_hi", 32'(rx_ready), 32'(1));
    q_rd.push_back(8'h37);
    tick();
    chk("rx_rdata", 32'(mem_rdata), 32'(q_rd.pop_front()));
    mem_a = 32'h0;
    #1 chk("rx_ready_off", 32'(rx_ready), 32'(0));
    mem_a     = 32'h30000;
    mem_wr    = 1'b1;
    mem_wdata = 8'h00;
    #1 chk("rx_ready_wr", 32'(rx_ready), 32'(0));
    tick();
    mem_wr   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h55;
    #1 chk("rx_ready_novalid", 32'(rx_ready), 32'(0));
    q_rd.push_back(8'h00);
    tick();
    chk("rx_rdata_novalid", 32'(mem_rdata), 32'(q_rd.pop_front()));
    chk("rx_nopush", 32'(tx_valid), 32'(0));

    // Counter snapshot
    for (int i = 0; i < 400 && model_cnt < 32'd300; i++) idle();
    snap = model_cnt;
    rd(32'h30004, snap[7:0]);
    rd(32'h30005, snap[15:8]);
    rd(32'h30006, snap[23:16]);
    rd(32'h30007, snap[31:24]);
    repeat (3) idle();
    rd(32'h30005, snap[15:8]);

    // Program stop
    tx_wr(32'h30004, 8'hFF);
    chk("stop_set", 32'(program_stop), 32'(1));
    rd(32'h30004, model_cnt[7:0]);
    repeat (5) idle();
    rd(32'h30004, model_cnt[7:0]);
    rd(32'h30005, model_cnt[15:8]);
    drain();

    // Reset mid-operation
    for (int d = 8'h11; d <= 8'h19; d++) tx_wr(32'h30000, 8'(d));
    pop_n(3);
    chk("pre_rst_stop", 32'(program_stop), 32'(1));
    rst_in = 1'b1;
    idle();
    rst_in  = 1'b0;
    q_tx.delete();
    exp_ovf = 1'b0;
    chk_tx();
    chk("post_rst_stop", 32'(program_stop), 32'(0));
    chk("post_rst_rdata", 32'(mem_rdata), 32'(0));
    rd(32'h30004, model_cnt[7:0]);
    rd(32'h00010, 8'hA5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
